// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: reference conversions and the stage bit-range
// arithmetic used to split a decode across pipeline registers.
package gray_pkg;

  localparam int unsigned MAXW = 64;

  function automatic int unsigned chunk_f(input int unsigned width, input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  // Highest bit resolved by stage s; negative when the stage has nothing left.
  function automatic int stage_hi_f(input int unsigned width, input int unsigned stages,
                                    input int unsigned s);
    return int'(width) - 1 - int'(s * chunk_f(width, stages));
  endfunction

  function automatic int stage_lo_f(input int unsigned width, input int unsigned stages,
                                    input int unsigned s);
    int lo;
    lo = int'(width) - int'((s + 1) * chunk_f(width, stages));
    return (lo < 0) ? 0 : lo;
  endfunction

  function automatic logic [MAXW-1:0] gray2bin_f(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int unsigned k = 1; k < MAXW; k++) begin
      b[MAXW-1-k] = b[MAXW-k] ^ g[MAXW-1-k];
    end
    return b;
  endfunction

  function automatic logic [MAXW-1:0] bin2gray_f(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// One pipeline register of the Gray decoder: resolves bits HI..LO of the word
// (bits above HI already binary, bits below LO left as Gray).
module gray2bin_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int          HI    = 3,
  parameter int          LO    = 0
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Bit HI+1 is already binary, so each resolved bit is a flat XOR reduction
  // from that anchor down to itself instead of a rippling chain.
  localparam int TOP = (HI >= int'(WIDTH) - 1) ? int'(WIDTH) - 1 : HI + 1;

  logic [WIDTH-1:0] dec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i <= HI && i >= LO && i < int'(WIDTH) - 1) begin : g_res
      assign dec[i] = ^up_data[TOP:i];
    end else begin : g_pass
      assign dec[i] = up_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= dec;
      end
    end
  end

endmodule

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready on both sides; STAGES
// registers, full throughput, bubbles collapse under backpressure.
module gray2bin_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin
);

  logic [STAGES:0]  vld;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [STAGES-1:0] ld;

  assign vld[0] = in_valid;
  assign dat[0] = in_gray;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // A stage loads if it or any stage downstream is empty, or the output pops.
    assign ld[s] = ~(&vld[STAGES:s+1]) | out_ready;

    gray2bin_stage #(
      .WIDTH (WIDTH),
      .HI    (stage_hi_f(WIDTH, STAGES, s)),
      .LO    (stage_lo_f(WIDTH, STAGES, s))
    ) u_stage (
      .clk      (clk),
      .srstn    (srstn),
      .load     (ld[s]),
      .up_valid (vld[s]),
      .up_data  (dat[s]),
      .valid    (vld[s+1]),
      .data     (dat[s+1])
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES];
  assign out_bin   = dat[STAGES];

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Scoreboard bench: drivers push expected words at acceptance, monitors pop
// and compare at every output handshake.
module tb_gray2bin_pipe;
  import gray_pkg::*;

  typedef struct {
    logic [63:0] bin;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: WIDTH=4, STAGES=2
  logic       a_valid = 1'b0, a_ready, a_ovld, a_ordy = 1'b0;
  logic [3:0] a_gray = '0, a_bin;
  exp_t       qa [$];
  bit         lat_a = 1'b0;
  int         run_a = 0, maxrun_a = 0;

  gray2bin_pipe #(.WIDTH(4), .STAGES(2)) u_dut (
    .clk(clk), .srstn(srstn), .in_valid(a_valid), .in_ready(a_ready), .in_gray(a_gray),
    .out_valid(a_ovld), .out_ready(a_ordy), .out_bin(a_bin)
  );

  // Instances B/C: WIDTH=8 with STAGES=1 and STAGES=8
  logic       bc_valid [2], bc_ready [2], bc_ovld [2], bc_ordy [2];
  logic [7:0] bc_gray [2], bc_bin [2];
  exp_t       qbc [2][$];
  bit         lat_bc [2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_bc
    gray2bin_pipe #(.WIDTH(8), .STAGES(g == 0 ? 1 : 8)) u_dut_bc (
      .clk(clk), .srstn(srstn), .in_valid(bc_valid[g]), .in_ready(bc_ready[g]),
      .in_gray(bc_gray[g]), .out_valid(bc_ovld[g]), .out_ready(bc_ordy[g]), .out_bin(bc_bin[g])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (bc_ovld[g] && bc_ordy[g]) begin
        if (qbc[g].size() == 0) begin
          chk($sformatf("w8_%0d_spurious_out", g), 64'd1, 64'd0);
        end else begin
          e = qbc[g].pop_front();
          chk($sformatf("w8_%0d_data", g), 64'(bc_bin[g]), e.bin);
          if (lat_bc[g]) chk($sformatf("w8_%0d_latency", g), 64'(cyc - e.cyc), 64'(g == 0 ? 1 : 8));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    run_a = a_ovld ? run_a + 1 : 0;
    if (run_a > maxrun_a) maxrun_a = run_a;
    if (a_ovld && a_ordy) begin
      if (qa.size() == 0) begin
        chk("a_spurious_out", 64'd1, 64'd0);
      end else begin
        e = qa.pop_front();
        chk("a_data", 64'(a_bin), e.bin);
        if (lat_a) chk("a_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_a(input logic [3:0] g, input logic [3:0] expb, output int waited);
    exp_t e;
    a_valid = 1'b1;
    a_gray  = g;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (a_ready) break;
      waited++;
      if (waited > 200) begin
        chk("a_push_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    e.bin = 64'(expb);
    e.cyc = cyc;
    qa.push_back(e);
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_gray  = 4'($urandom);
  endtask

  task automatic push_bc(input int g, input logic [7:0] gr, input logic [7:0] expb);
    exp_t e;
    int   waited = 0;
    bc_valid[g] = 1'b1;
    bc_gray[g]  = gr;
    forever begin
      @(negedge clk);
      if (bc_ready[g]) break;
      waited++;
      if (waited > 200) begin
        chk($sformatf("w8_%0d_push_timeout", g), 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    e.bin = 64'(expb);
    e.cyc = cyc;
    qbc[g].push_back(e);
    @(posedge clk); #1;
    bc_valid[g] = 1'b0;
  endtask

  task automatic run_rand(input int g);
    exp_t e;
    int   sent = 0, guard = 0;
    bit   acc = 1'b0;
    lat_bc[g]  = 1'b1;
    bc_ordy[g] = 1'b1;
    push_bc(g, 8'b1000_0000, 8'd255);
    repeat (12) @(posedge clk);
    #1;
    chk($sformatf("w8_%0d_corner_drained", g), 64'(qbc[g].size()), 64'd0);
    lat_bc[g] = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      guard++;
      @(posedge clk); #1;
      if (acc) bc_valid[g] = 1'b0;
      bc_ordy[g] = ($urandom_range(0, 3) != 0);
      if (!bc_valid[g]) begin
        bc_gray[g] = 8'($urandom);
        if ($urandom_range(0, 3) != 0) bc_valid[g] = 1'b1;
      end
      @(negedge clk);
      acc = bc_valid[g] && bc_ready[g];
      if (acc) begin
        e.bin = gray2bin_f(64'(bc_gray[g]));
        e.cyc = cyc;
        qbc[g].push_back(e);
        sent++;
      end
    end
    chk($sformatf("w8_%0d_words_sent", g), 64'(sent), 64'd1000);
    @(posedge clk); #1;
    bc_valid[g] = 1'b0;
    bc_ordy[g]  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk($sformatf("w8_%0d_drained", g), 64'(qbc[g].size()), 64'd0);
  endtask

  logic [3:0] sweep_g [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int unsigned g = 0; g < 2; g++) begin
      bc_valid[g] = 1'b0; bc_ordy[g] = 1'b0; bc_gray[g] = '0; lat_bc[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 srstn = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(a_ovld), 64'd0);
    chk("reset_out_bin", 64'(a_bin), 64'd0);
    chk("reset_in_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    // Full sweep, back-to-back, no backpressure
    a_ordy = 1'b1; lat_a = 1'b1; maxrun_a = 0;
    for (int unsigned i = 0; i < 16; i++) push_a(sweep_g[i], 4'(i), w);
    repeat (5) @(posedge clk);
    #1;
    chk("sweep_valid_run", 64'(maxrun_a), 64'd16);
    chk("sweep_drained", 64'(qa.size()), 64'd0);

    // Backpressure: two accepts fill the pipe, third waits
    lat_a = 1'b0; a_ordy = 1'b0;
    push_a(4'b1000, 4'd15, w);
    push_a(4'b1010, 4'd12, w);
    a_valid = 1'b1; a_gray = 4'b1111;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(a_ready), 64'd0);
      chk("stall_out_valid", 64'(a_ovld), 64'd1);
      chk("stall_out_bin", 64'(a_bin), 64'd15);
      @(posedge clk); #1;
    end
    a_ordy = 1'b1;
    push_a(4'b1111, 4'd10, w);
    chk("full_pop_push_no_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("occupancy_after_pop_push", 64'({a_ovld, a_bin}), 64'({1'b1, 4'd12}));
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    chk("backpressure_drained", 64'(qa.size()), 64'd0);

    // Bubbles: valid 1,0,1,0
    lat_a = 1'b1;
    push_a(4'b0110, 4'd4, w);
    @(posedge clk); #1;
    push_a(4'b1101, 4'd9, w);
    repeat (5) @(posedge clk);
    #1;
    chk("bubble_drained", 64'(qa.size()), 64'd0);

    // Reset with two words in flight
    lat_a = 1'b0; a_ordy = 1'b0;
    push_a(4'b0011, 4'd2, w);
    push_a(4'b0101, 4'd6, w);
    srstn = 1'b0;
    @(posedge clk); #1;
    srstn = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(a_ovld), 64'd0);
    chk("midreset_out_bin", 64'(a_bin), 64'd0);
    chk("midreset_in_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    a_ordy = 1'b1; lat_a = 1'b1;
    push_a(4'b0001, 4'd1, w);
    repeat (6) @(posedge clk);
    #1;
    chk("after_reset_drained", 64'(qa.size()), 64'd0);
    lat_a = 1'b0;

    // Parameter corners, driven concurrently
    fork
      run_rand(0);
      run_rand(1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
